// File: rtl/hd_pair_encoder.sv
// Hamming(7,4) pair encoder: groups nibbles into code-word pairs and queues them on valid/ready.
// Optional bit-error injection on the in_err_pos port when HD_ERR_INJECT_EN is defined.
//
// state       | meaning
// WAIT_FIRST  | waiting for first nibble of a pair
// WAIT_SECOND | first word held in hold_cw1, waiting for second nibble
module hd_pair_encoder #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [6:0] code_word1,
   output logic [6:0] code_word2,
   output logic [7:0] pair_cnt
`ifdef HD_ERR_INJECT_EN
   ,
   input  logic [2:0] in_err_pos
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {WAIT_FIRST, WAIT_SECOND} state_t;

   state_t            state, state_nxt;
   logic [6:0]        hold_cw1;
   logic [13:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              push, pop, latch_first;
   logic [6:0]        enc_word;

   function automatic logic [6:0] hamming_enc(input logic [3:0] d);
      return {d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d};
   endfunction

`ifdef HD_ERR_INJECT_EN
   // err_pos 7 is the "no injection" code
   always_comb begin
      enc_word = hamming_enc(in_data);
      if (in_err_pos != 3'd7)
         enc_word = enc_word ^ (7'b1 << in_err_pos);
   end
`else
   always_comb enc_word = hamming_enc(in_data);
`endif

   assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b1;
      push        = 1'b0;
      latch_first = 1'b0;
      case (state)
         WAIT_FIRST: begin
            if (in_valid) begin
               latch_first = 1'b1;
               state_nxt   = WAIT_SECOND;
            end
         end
         WAIT_SECOND: begin
            in_ready = !fifo_full;
            if (in_valid && !fifo_full) begin
               push      = 1'b1;
               state_nxt = WAIT_FIRST;
            end
         end
         default: state_nxt = WAIT_FIRST;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= WAIT_FIRST;
         hold_cw1 <= '0;
      end else begin
         state <= state_nxt;
         if (latch_first)
            hold_cw1 <= enc_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            fifo_mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         pair_cnt   <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {hold_cw1, enc_word};
            wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr   <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            pair_cnt <= pair_cnt + 8'd1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Head is masked to zero when empty so stale entries never leak out
   assign code_word1 = out_valid ? fifo_mem[rd_ptr][13:7] : 7'd0;
   assign code_word2 = out_valid ? fifo_mem[rd_ptr][6:0]  : 7'd0;

endmodule

// File: tb/tb_hd_pair_encoder.sv
// Directed bench for hd_pair_encoder with hand-computed code words.
// Exercises the error-injection port when HD_ERR_INJECT_EN is defined.
module tb_hd_pair_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] code_word1;
   logic [6:0] code_word2;
   logic [7:0] pair_cnt;
`ifdef HD_ERR_INJECT_EN
   logic [2:0] in_err_pos;
`endif

   int n_checks = 0;
   int n_errors = 0;

   hd_pair_encoder #(.FIFO_DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .code_word1 (code_word1),
      .code_word2 (code_word2),
      .pair_cnt   (pair_cnt)
`ifdef HD_ERR_INJECT_EN
      ,
      .in_err_pos (in_err_pos)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b0;
`ifdef HD_ERR_INJECT_EN
      in_err_pos = 3'd7;
`endif
      step();
      step();
      chk("rst_in_ready",  16'(in_ready),   16'h1);
      chk("rst_out_valid", 16'(out_valid),  16'h0);
      chk("rst_cw1",       16'(code_word1), 16'h0);
      chk("rst_cw2",       16'(code_word2), 16'h0);
      chk("rst_pair_cnt",  16'(pair_cnt),   16'h0);
      rst = 1'b0;
      step();

      // basic pairs with latency check
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 4'h0;
      step();
      in_data = 4'hF;
      step();
      chk("lat_out_valid", 16'(out_valid),  16'h1);
      chk("p1_cw1",        16'(code_word1), 16'h00);
      chk("p1_cw2",        16'(code_word2), 16'h7F);
      in_data = 4'hB;
      step();
      chk("p1_popped",     16'(out_valid),  16'h0);
      chk("p1_pair_cnt",   16'(pair_cnt),   16'h1);
      in_data = 4'h5;
      step();
      chk("p2_out_valid",  16'(out_valid),  16'h1);
      chk("p2_cw1",        16'(code_word1), 16'h1B);
      chk("p2_cw2",        16'(code_word2), 16'h55);
      in_valid = 1'b0;
      step();
      chk("p2_pair_cnt",   16'(pair_cnt),   16'h2);
      chk("p2_empty",      16'(out_valid),  16'h0);

      // backpressure: 6 nibbles offered with out_ready low
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         in_valid = 1'b1;
         in_data  = 4'(i);
         chk($sformatf("bp_in_ready_%0d", i), 16'(in_ready), (i <= 5) ? 16'h1 : 16'h0);
         step();
      end
      chk("bp_full_ready", 16'(in_ready),   16'h0);
      chk("bp_out_valid",  16'(out_valid),  16'h1);
      chk("bp_h0_cw1",     16'(code_word1), 16'h31);
      chk("bp_h0_cw2",     16'(code_word2), 16'h52);
      out_ready = 1'b1;
      step();
      chk("bp_h1_ready",   16'(in_ready),   16'h1);
      chk("bp_h1_cw1",     16'(code_word1), 16'h63);
      chk("bp_h1_cw2",     16'(code_word2), 16'h64);
      step();
      chk("pp_out_valid",  16'(out_valid),  16'h1);
      chk("pp_cw1",        16'(code_word1), 16'h55);
      chk("pp_cw2",        16'(code_word2), 16'h36);
      chk("pp_pair_cnt",   16'(pair_cnt),   16'h4);
      in_valid = 1'b0;
      step();
      chk("bp_drained",    16'(out_valid),  16'h0);
      chk("bp_pair_cnt",   16'(pair_cnt),   16'h5);

      // stream 250 more pairs to reach 255 pops, then one more to wrap
      in_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         in_data = 4'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      chk("wrap_pre_cnt",  16'(pair_cnt),   16'hFF);
      chk("wrap_pre_empty",16'(out_valid),  16'h0);
      in_valid = 1'b1;
      in_data  = 4'h3;
      step();
      in_data = 4'h4;
      step();
      in_valid = 1'b0;
      step();
      chk("wrap_cnt",      16'(pair_cnt),   16'h0);

      // reset in WAIT_SECOND with one pair buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'h1;
      step();
      in_data = 4'h2;
      step();
      in_data = 4'h3;
      step();
      in_valid = 1'b0;
      chk("mr_pre_valid",  16'(out_valid),  16'h1);
      rst = 1'b1;
      #1;
      chk("mr_out_valid",  16'(out_valid),  16'h0);
      chk("mr_in_ready",   16'(in_ready),   16'h1);
      chk("mr_cw1",        16'(code_word1), 16'h0);
      chk("mr_pair_cnt",   16'(pair_cnt),   16'h0);
      step();
      rst = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'h9;
      step();
      in_data = 4'hA;
      step();
      in_valid = 1'b0;
      chk("mr_new_valid",  16'(out_valid),  16'h1);
      chk("mr_new_cw1",    16'(code_word1), 16'h49);
      chk("mr_new_cw2",    16'(code_word2), 16'h2A);
      out_ready = 1'b1;
      step();
      chk("mr_single",     16'(out_valid),  16'h0);
      chk("mr_pop_cnt",    16'(pair_cnt),   16'h1);

`ifdef HD_ERR_INJECT_EN
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_data    = 4'h5;
      in_err_pos = 3'd3;
      step();
      in_err_pos = 3'd7;
      step();
      in_valid = 1'b0;
      chk("ei_cw1",        16'(code_word1), 16'h5D);
      chk("ei_cw2",        16'(code_word2), 16'h55);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
